// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed seven-segment scanner for up to 8 hex digits.
// Selects one of CHANNELS debug sources (manual select or automatic rotation) and shows
// a tear-free snapshot of it. The snapshot is captured once per frame.
//
// Optional build macro:
//   SEG_LZB_EN - leading-zero blanking. Digits above the most significant non-zero nibble
//                are blanked; their dp is still shown and digit 0 is never blanked.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   data    CHANNELS*DIGITS nibbles; channel c at [c*DIGITS*4 +: DIGITS*4], digit 0 rightmost
//   dp      decimal-point requests per channel/digit, active-high
//   ch_sel  manual channel select (ignored if out of range)
//   auto    1 = rotate channels every DWELL_FRAMES frames
//   freeze  1 = hold snapshot, channel and dwell count (scan keeps running)
//   AN      digit enables, active-low one-hot
//   SEG     {dp,g,f,e,d,c,b,a}, active-low
//   cur_ch  channel currently captured
module seg_scan_display #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DWELL_FRAMES = 256,
  localparam int unsigned CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DIGITS*4-1:0] data,
  input  logic [CHANNELS*DIGITS-1:0]   dp,
  input  logic [CW-1:0]                ch_sel,
  input  logic                         auto,
  input  logic                         freeze,
  output logic [DIGITS-1:0]            AN,
  output logic [7:0]                   SEG,
  output logic [CW-1:0]                cur_ch
);

  localparam int unsigned PW  = $clog2(SCAN_DIV);
  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int unsigned NW  = DIGITS * 4;

  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DWW-1:0]    dwell_q, dwell_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [NW-1:0]     snap_q, snap_d;
  logic [DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic              tick, last_digit, fb, sel_ok;
  logic [NW-1:0]     data_sel;
  logic [DIGITS-1:0] dp_sel;
  logic [3:0]        nib;
  logic              dp_bit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick       = (pre_q == PW'(SCAN_DIV - 1));
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign fb         = tick && last_digit;
  assign sel_ok     = (32'(ch_sel) < CHANNELS);

  // Prescaler and digit index
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
  end

  // Channel selection and dwell counting
  always_comb begin
    ch_d    = ch_q;
    dwell_d = dwell_q;
    if (!freeze) begin
      if (!auto) begin
        dwell_d = '0;
        if (fb && sel_ok) begin
          ch_d = ch_sel;
        end
      end else if (fb) begin
        if (dwell_q == DWW'(DWELL_FRAMES - 1)) begin
          dwell_d = '0;
          ch_d    = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    end
  end

  // Snapshot follows the channel chosen on this same edge
  always_comb begin
    data_sel = data[NW-1:0];
    dp_sel   = dp[DIGITS-1:0];
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ch_d == CW'(c)) begin
        data_sel = data[c*NW +: NW];
        dp_sel   = dp[c*DIGITS +: DIGITS];
      end
    end
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    if (fb && !freeze) begin
      snap_d    = data_sel;
      snap_dp_d = dp_sel;
    end
  end

  // Digit drive, registered one clk behind idx
  always_comb begin
    nib    = snap_q[3:0];
    dp_bit = snap_dp_q[0];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      an_d[i] = (idx_q != IW'(i));
      if (idx_q == IW'(i)) begin
        nib    = snap_q[i*4 +: 4];
        dp_bit = snap_dp_q[i];
      end
    end
    seg_d = {~dp_bit, hex_to_seg(nib)};
`ifdef SEG_LZB_EN
    begin : lzb
      logic [IW-1:0] msd;
      msd = '0;
      for (int unsigned i = 1; i < DIGITS; i++) begin
        if (snap_q[i*4 +: 4] != 4'h0) begin
          msd = IW'(i);
        end
      end
      if (idx_q > msd) begin
        seg_d[6:0] = 7'h7F;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q     <= '0;
      idx_q     <= '0;
      dwell_q   <= '0;
      ch_q      <= '0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      an_q      <= '1;
      seg_q     <= 8'hFF;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      ch_q      <= ch_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign AN     = an_q;
  assign SEG    = seg_q;
  assign cur_ch = ch_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (DIGITS=4, CHANNELS=2, SCAN_DIV=4,
// DWELL_FRAMES=2). A frame-level model predicts AN/SEG/cur_ch for every edge; the
// prediction is queued before the edge and compared after it. Directed checks cover
// reset, scan order, snapshot, rotation, freeze, dp and leading-zero blanking.
module tb_seg_scan_display;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned CHANNELS     = 2;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DWELL_FRAMES = 2;
  localparam int unsigned FRAME        = DIGITS * SCAN_DIV;

`ifdef SEG_LZB_EN
  localparam logic [31:0] ExpZero = 32'hFFFFFFC0;
  localparam logic [31:0] Exp0030 = 32'hFFFFB0C0;
`else
  localparam logic [31:0] ExpZero = 32'hC0C0C0C0;
  localparam logic [31:0] Exp0030 = 32'hC0C0B0C0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [0:0]  ch_sel;
  logic        auto;
  logic        freeze;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [0:0]  cur_ch;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       ch;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  // Model state: m_k counts edges since reset release
  int          m_k;
  logic        m_ch;
  int          m_dwell;
  logic [15:0] m_snap;
  logic [3:0]  m_sdp;

  seg_scan_display #(
    .DIGITS      (DIGITS),
    .CHANNELS    (CHANNELS),
    .SCAN_DIV    (SCAN_DIV),
    .DWELL_FRAMES(DWELL_FRAMES)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .dp    (dp),
    .ch_sel(ch_sel),
    .auto  (auto),
    .freeze(freeze),
    .AN    (an),
    .SEG   (seg),
    .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k     = 0;
    m_ch    = 1'b0;
    m_dwell = 0;
    m_snap  = '0;
    m_sdp   = '0;
  endtask

  function automatic logic [7:0] model_seg(input int d);
    logic [3:0] nib;
    logic [7:0] s;
    nib = m_snap[d*4 +: 4];
    s   = {~m_sdp[d], seg_lut[nib][6:0]};
`ifdef SEG_LZB_EN
    begin
      int msd;
      msd = 0;
      for (int i = 1; i < 4; i++) if (m_snap[i*4 +: 4] != 4'h0) msd = i;
      if (d > msd) s[6:0] = 7'h7F;
    end
`endif
    return s;
  endfunction

  // Predict this edge, queue it, advance one clock and compare.
  task automatic step();
    exp_t e;
    int   idx;
    bit   fb;
    idx   = (m_k / SCAN_DIV) % DIGITS;
    fb    = (m_k % FRAME) == FRAME - 1;
    e.an  = ~(4'b0001 << idx);
    e.seg = model_seg(idx);
    if (!freeze) begin
      if (!auto) begin
        m_dwell = 0;
        if (fb) m_ch = ch_sel[0];
      end else if (fb) begin
        if (m_dwell == DWELL_FRAMES - 1) begin
          m_dwell = 0;
          m_ch    = ~m_ch;
        end else begin
          m_dwell++;
        end
      end
      if (fb) begin
        m_snap = data[int'(m_ch)*16 +: 16];
        m_sdp  = dp[int'(m_ch)*4 +: 4];
      end
    end
    e.ch = m_ch;
    sb_q.push_back(e);
    m_k++;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("sb_an", 32'(an), 32'(e.an));
    check_eq("sb_seg", 32'(seg), 32'(e.seg));
    check_eq("sb_ch", 32'(cur_ch), 32'(e.ch));
  endtask

  task automatic sync_frame();
    step();
    for (int i = 0; i < FRAME && (m_k % FRAME) != 0; i++) step();
  endtask

  // Run one frame, collecting SEG per lit digit as {d3,d2,d1,d0}.
  task automatic expect_frame(input string tag, input int chg_at, input logic [31:0] chg_data,
                              input logic [31:0] exp);
    logic [31:0] seen;
    seen = '1;
    for (int s = 0; s < FRAME; s++) begin
      if (s == chg_at) data = chg_data;
      step();
      for (int d = 0; d < 4; d++) if (an == ~(4'b0001 << d)) seen[d*8 +: 8] = seg;
    end
    check_eq(tag, seen, exp);
  endtask

  initial begin
    rst    = 1'b0;
    data   = '0;
    dp     = '0;
    ch_sel = 1'b0;
    auto   = 1'b0;
    freeze = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_hold_an", 32'(an), 32'hF);
    check_eq("rst_hold_seg", 32'(seg), 32'hFF);
    rst = 1'b1;

    // Scan order after release
    for (int j = 1; j <= 17; j++) begin
      step();
      check_eq("scan_an", 32'(an), 32'(an_tab[((j - 1) / 4) % 4]));
      if (j == 1) check_eq("first_seg", 32'(seg), 32'hC0);
    end

    // Asynchronous reset mid-scan, with channel 1 selected
    ch_sel = 1'b1;
    for (int i = 0; i < 32 && !(cur_ch == 1'b1 && an == 4'hB); i++) step();
    check_eq("pre_rst_an", 32'(an), 32'hB);
    check_eq("pre_rst_ch", 32'(cur_ch), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_an", 32'(an), 32'hF);
    check_eq("async_rst_seg", 32'(seg), 32'hFF);
    check_eq("async_rst_ch", 32'(cur_ch), 32'h0);
    ch_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Snapshot and mid-frame change
    data = 32'h4567_12AF;
    sync_frame();
    expect_frame("snap_12af", -1, 32'h0, 32'hF9A4888E);
    expect_frame("snap_mid_hold", 6, 32'h4567_0000, 32'hF9A4888E);
    expect_frame("snap_zero", -1, 32'h0, ExpZero);

    // Automatic rotation, then manual select
    auto = 1'b1;
    repeat (31) step();
    check_eq("auto_ch_hold", 32'(cur_ch), 32'h0);
    step();
    check_eq("auto_ch_to1", 32'(cur_ch), 32'h1);
    repeat (32) step();
    check_eq("auto_ch_to0", 32'(cur_ch), 32'h0);
    ch_sel = 1'b1;
    auto   = 1'b0;
    repeat (16) step();
    check_eq("manual_ch1", 32'(cur_ch), 32'h1);

    // Freeze holds snapshot and channel despite new data and select
    freeze = 1'b1;
    ch_sel = 1'b0;
    data   = 32'h8888_8888;
    for (int f = 0; f < 3; f++) begin
      expect_frame("freeze_frame", -1, 32'h0, 32'h999282F8);
      check_eq("freeze_ch", 32'(cur_ch), 32'h1);
    end

    // Decimal point on channel 0 digit 1
    freeze = 1'b0;
    dp     = 8'h02;
    repeat (16) step();
    check_eq("dp_ch0", 32'(cur_ch), 32'h0);
    expect_frame("dp_digit1", -1, 32'h0, 32'h80800080);

    // Leading-zero blanking
    dp   = 8'h00;
    data = 32'h0000_0030;
    repeat (16) step();
    expect_frame("blank_0030", -1, 32'h0, Exp0030);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
